// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared types, thresholds and card value helper for the baccarat controller
package baccarat_pkg;

    localparam logic [3:0] NATURAL_MIN_DEF     = 4'd8;
    localparam logic [3:0] PLAYER_DRAW_MAX_DEF = 4'd5;
    localparam logic [3:0] DEALER_STAND_DEF    = 4'd7;

    typedef logic [3:0] score_t;
    typedef logic [3:0] rank_t;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_P1    = 4'd1,
        S_D1    = 4'd2,
        S_P2    = 4'd3,
        S_D2    = 4'd4,
        S_EVAL  = 4'd5,
        S_P3    = 4'd6,
        S_D3    = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    // Tens and face cards count as zero; the "none" rank 0 is also zero.
    function automatic score_t card_value(input rank_t rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// rtl/dealer_draw_rule.sv - dealer third-card decision from dealer score and player third-card value
module dealer_draw_rule
    import baccarat_pkg::*;
#(
    parameter logic [3:0] DEALER_STAND = DEALER_STAND_DEF
) (
    input  logic [3:0] i_dscore,
    input  logic [3:0] i_value,
    output logic       o_draw
);

    // Dealer tableau: the higher the dealer score, the narrower the band of player cards that still makes it draw.
    always_comb begin
        o_draw = 1'b0;
        if (i_dscore < DEALER_STAND) begin
            case (i_dscore)
                4'd0, 4'd1, 4'd2: o_draw = 1'b1;
                4'd3:             o_draw = (i_value != 4'd8);
                4'd4:             o_draw = (i_value >= 4'd2) && (i_value <= 4'd7);
                4'd5:             o_draw = (i_value >= 4'd4) && (i_value <= 4'd7);
                4'd6:             o_draw = (i_value >= 4'd6) && (i_value <= 4'd7);
                default:          o_draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/baccarat_ctrl.sv
// rtl/baccarat_ctrl.sv - card load sequencer and winner decode for one baccarat round
module baccarat_ctrl
    import baccarat_pkg::*;
#(
    parameter logic [3:0] NATURAL_MIN     = NATURAL_MIN_DEF,
    parameter logic [3:0] PLAYER_DRAW_MAX = PLAYER_DRAW_MAX_DEF,
    parameter logic [3:0] DEALER_STAND    = DEALER_STAND_DEF
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       round_done
);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] w_pvalue;
    logic       w_dealer_draw;

    assign w_pvalue = card_value(pcard3);

    dealer_draw_rule #(
        .DEALER_STAND (DEALER_STAND)
    ) u_dealer_draw_rule (
        .i_dscore (dscore),
        .i_value  (w_pvalue),
        .o_draw   (w_dealer_draw)
    );

    // State register; reset forces S_RESET immediately so no partial load escapes.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: fixed four-card deal, then third-card decisions from the datapath scores.
    always_comb begin
        w_next_state = S_RESET;
        case (r_state)
            S_RESET: w_next_state = S_P1;
            S_P1:    w_next_state = S_D1;
            S_D1:    w_next_state = S_P2;
            S_P2:    w_next_state = S_D2;
            S_D2:    w_next_state = S_EVAL;
            S_EVAL: begin
                if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                    w_next_state = S_DONE;
                end else if (pscore <= PLAYER_DRAW_MAX) begin
                    w_next_state = S_P3;
                end else if (dscore <= PLAYER_DRAW_MAX) begin
                    w_next_state = S_D3;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            // pcard3 and dscore here reflect the card loaded on the falling edge of this state.
            S_P3:    w_next_state = w_dealer_draw ? S_D3 : S_DONE;
            S_D3:    w_next_state = S_DONE;
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_RESET;
        endcase
    end

    // Output decode: one load enable per load state; lights compare the settled scores in S_DONE.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        round_done       = 1'b0;
        case (r_state)
            S_P1:   load_pcard1 = 1'b1;
            S_D1:   load_dcard1 = 1'b1;
            S_P2:   load_pcard2 = 1'b1;
            S_D2:   load_dcard2 = 1'b1;
            S_P3:   load_pcard3 = 1'b1;
            S_D3:   load_dcard3 = 1'b1;
            S_DONE: begin
                round_done       = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_baccarat_ctrl.sv
// tb/tb_baccarat_ctrl.sv - randomized and directed self-checking bench for baccarat_ctrl
module tb_baccarat_ctrl;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, round_done;

    logic [3:0] rule_d, rule_v;
    logic       rule_draw;

    int checks = 0;
    int errors = 0;

    // Cards the mock datapath hands out, in order P1 D1 P2 D2 P3 D3.
    logic [3:0] deck [6];
    logic [3:0] dp_p1, dp_p2, dp_p3, dp_d1, dp_d2, dp_d3;

    // Rows: dealer score 0..9; column v = player third-card value 0..9; '1' = dealer draws.
    string draw_tab [10] = '{
        "1111111111", "1111111111", "1111111111", "1111111101", "0011111100",
        "0000111100", "0000001100", "0000000000", "0000000000", "0000000000"
    };

    always #5 slow_clock = ~slow_clock;

    baccarat_ctrl dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .round_done       (round_done)
    );

    dealer_draw_rule u_rule (
        .i_dscore (rule_d),
        .i_value  (rule_v),
        .o_draw   (rule_draw)
    );

    function automatic int cv(input logic [3:0] rank);
        return (rank >= 4'd10) ? 0 : int'(rank);
    endfunction

    function automatic int tab_draw(input int d, input int v);
        return (draw_tab[d].getc(v) == "1") ? 1 : 0;
    endfunction

    // Behavioural datapath: card registers load on the falling edge, scores are mod-10 sums.
    always @(negedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            dp_p1 = 0; dp_p2 = 0; dp_p3 = 0; dp_d1 = 0; dp_d2 = 0; dp_d3 = 0;
        end else begin
            if (load_pcard1) dp_p1 = deck[0];
            if (load_dcard1) dp_d1 = deck[1];
            if (load_pcard2) dp_p2 = deck[2];
            if (load_dcard2) dp_d2 = deck[3];
            if (load_pcard3) dp_p3 = deck[4];
            if (load_dcard3) dp_d3 = deck[5];
        end
    end

    assign pscore = 4'((cv(dp_p1) + cv(dp_p2) + cv(dp_p3)) % 10);
    assign dscore = 4'((cv(dp_d1) + cv(dp_d2) + cv(dp_d3)) % 10);
    assign pcard3 = dp_p3;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, int'({load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3,
                         player_win_light, dealer_win_light, round_done}), 0);
    endtask

    function automatic int load_code();
        if (load_pcard1) return 1;
        if (load_dcard1) return 2;
        if (load_pcard2) return 3;
        if (load_dcard2) return 4;
        if (load_pcard3) return 5;
        if (load_dcard3) return 6;
        return 0;
    endfunction

    // Plays one full round from reset and compares load order, timing and lights against the rules.
    task automatic run_round(input logic [3:0] p1, d1, p2, d2, p3, d3);
        int exp_seq[$];
        int got_seq[$];
        int ps, ds, pv, exp_edge, done_edge, after, n;
        resetb = 1'b0;
        deck[0] = p1; deck[1] = d1; deck[2] = p2; deck[3] = d2; deck[4] = p3; deck[5] = d3;
        ps = (cv(p1) + cv(p2)) % 10;
        ds = (cv(d1) + cv(d2)) % 10;
        exp_seq = '{1, 2, 3, 4};
        if (ps >= 8 || ds >= 8) begin
        end else if (ps <= 5) begin
            exp_seq.push_back(5);
            pv = cv(p3);
            ps = (ps + pv) % 10;
            if (tab_draw(ds, pv) == 1) begin
                exp_seq.push_back(6);
                ds = (ds + cv(d3)) % 10;
            end
        end else if (ds <= 5) begin
            exp_seq.push_back(6);
            ds = (ds + cv(d3)) % 10;
        end
        exp_edge = 2 + exp_seq.size();

        @(negedge slow_clock);
        resetb = 1'b1;
        done_edge = 0;
        after = 0;
        n = 0;
        while (after < 3 && n < 20) begin
            @(posedge slow_clock);
            n++;
            @(negedge slow_clock);
            check("onehot", int'($countones({load_pcard1, load_dcard1, load_pcard2,
                                             load_dcard2, load_pcard3, load_dcard3}) > 1), 0);
            if (load_code() != 0) got_seq.push_back(load_code());
            if (round_done && done_edge == 0) done_edge = n;
            if (done_edge != 0) after++;
        end
        check("done_edge", done_edge, exp_edge);
        check("nloads", got_seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < got_seq.size(); i++)
            check("load_seq", got_seq[i], exp_seq[i]);
        check("round_done", int'(round_done), 1);
        check("player_light", int'(player_win_light), int'(ps >= ds));
        check("dealer_light", int'(dealer_win_light), int'(ds >= ps));
    endtask

    initial begin
        rule_d = 0;
        rule_v = 0;
        deck = '{default: 4'd0};
        resetb = 1'b0;
        #12;
        check_idle("reset_outputs");

        // Dealer rule sweep against the tableau.
        for (int d = 0; d < 10; d++) begin
            for (int v = 0; v < 10; v++) begin
                rule_d = 4'(d);
                rule_v = 4'(v);
                #1;
                check($sformatf("rule_d%0d_v%0d", d, v), int'(rule_draw), tab_draw(d, v));
            end
        end

        // Natural 8 vs 3, player wins.
        run_round(4'd3, 4'd1, 4'd5, 4'd2, 4'd9, 4'd9);
        // Both draw: 4 vs 5, player 6 -> 0, dealer 4 -> 9.
        run_round(4'd1, 4'd2, 4'd3, 4'd3, 4'd6, 4'd4);
        // Dealer 4 stands on a face card.
        run_round(4'd1, 4'd2, 4'd1, 4'd2, 4'd12, 4'd5);
        // Player stands on 7, dealer 5 draws.
        run_round(4'd3, 4'd2, 4'd4, 4'd3, 4'd1, 4'd1);
        // Both stand on 7: tie.
        run_round(4'd3, 4'd3, 4'd4, 4'd4, 4'd1, 4'd1);

        // Asynchronous reset in the middle of S_D1.
        resetb = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
        @(posedge slow_clock);
        @(posedge slow_clock);
        #2;
        check("mid_in_d1", int'(load_dcard1), 1);
        resetb = 1'b0;
        #1;
        check_idle("mid_reset_idle");
        run_round(4'd2, 4'd11, 4'd13, 4'd7, 4'd3, 4'd8);

        for (int r = 0; r < 40; r++) begin
            run_round(4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                      4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)),
                      4'($urandom_range(1, 13)), 4'($urandom_range(1, 13)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
